// File: rtl/data_mem_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
// Misaligned-trap behaviour is selected in data_mem_lsu by DM_MISALIGN_TRAP_EN.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } dm_state_t;

  function automatic logic [3:0] be_gen(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    case (f3)
      F3_B:    return 4'b0001 << lo;
      F3_H:    return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(
    input logic [2:0]  f3,
    input logic [1:0]  lo,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'h0, b};
      F3_HU:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Store encodings outside SB/SH behave as SW; loads outside
  // LB/LH/LBU/LHU behave as LW.
  function automatic logic mis_chk(
    input logic [2:0] f3,
    input logic [1:0] lo,
    input logic       st
  );
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return lo[0];
      F3_BU:   return st ? |lo : 1'b0;
      F3_HU:   return st ? |lo : lo[0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(
    input logic [2:0] f3,
    input logic [1:0] lo,
    input logic       st
  );
    case (f3)
      F3_B:    return lo;
      F3_H:    return {lo[1], 1'b0};
      F3_BU:   return st ? 2'b00 : lo;
      F3_HU:   return st ? 2'b00 : {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bank.sv
// Word-organised synchronous RAM with byte write enables
// and a registered read port.
module data_mem_bank #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32I load/store unit: valid/ready requests, lane-aware RAM access,
// registered responses. Define DM_MISALIGN_TRAP_EN to trap misalignment.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  misalign
);

  localparam int AW = DM_ADDRESS - 2;

  if (DATA_W != 32) begin : g_bad_width
    $error("data_mem_lsu: DATA_W must be 32");
  end

  dm_state_t   state;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        mis_q;
  logic [AW-1:0] idx_q;

  logic        acc;
  logic        st;
  logic        trap;
  logic [1:0]  lo;
  logic [3:0]  be;
  logic [AW-1:0] idx;
  logic [31:0] rdata;

  assign req_ready = (state == IDLE);
  assign acc = req_valid && req_ready && (MemRead || MemWrite);
  assign st  = !MemRead && MemWrite;

`ifdef DM_MISALIGN_TRAP_EN
  assign trap = mis_chk(Funct3, a[1:0], st);
  assign lo   = a[1:0];
`else
  assign trap = 1'b0;
  assign lo   = align_lo(Funct3, a[1:0], st);
`endif

  // Stores commit at the accept edge, so a following load sees them.
  assign be  = (acc && st && !trap) ? be_gen(Funct3, lo) : 4'b0000;
  assign idx = (state == IDLE) ? a[DM_ADDRESS-1:2] : idx_q;

  data_mem_bank #(.AW(AW)) u_bank (
    .clk   (clk),
    .addr  (idx),
    .be    (be),
    .wdata (st_data(Funct3, wd)),
    .re    (state == RD_WAIT),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rd        <= '0;
      misalign  <= 1'b0;
      st_q      <= 1'b0;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      mis_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      misalign  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            st_q  <= st;
            f3_q  <= Funct3;
            lo_q  <= lo;
            mis_q <= trap;
            idx_q <= a[DM_ADDRESS-1:2];
            state <= st ? RESP : RD_WAIT;
          end
        end
        RD_WAIT: state <= RESP;
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          misalign  <= mis_q;
          if (!st_q && !mis_q) rd <= load_fmt(f3_q, lo_q, rdata);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: stores, sub-word loads,
// misalignment, mid-load reset and handshake behaviour.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  a;
  logic [31:0] wd;
  logic        rsp_valid;
  logic [31:0] rd;
  logic        misalign;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .a         (a),
    .wd        (wd),
    .rsp_valid (rsp_valid),
    .rd        (rd),
    .misalign  (misalign)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag,
                        input logic r, input logic w,
                        input logic [2:0] f3,
                        input logic [8:0] addr,
                        input logic [31:0] data,
                        input int exp_lat,
                        input logic exp_mis);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    MemRead = r;
    MemWrite = w;
    Funct3 = f3;
    a = addr;
    wd = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".mis"}, {31'h0, misalign}, {31'h0, exp_mis});
  endtask

  task automatic st_op(input string tag, input logic [2:0] f3,
                       input logic [8:0] addr, input logic [31:0] data,
                       input logic exp_mis);
    do_req(tag, 1'b0, 1'b1, f3, addr, data, 1, exp_mis);
  endtask

  task automatic ld_op(input string tag, input logic [2:0] f3,
                       input logic [8:0] addr, input logic [31:0] exp_rd,
                       input logic exp_mis);
    do_req(tag, 1'b1, 1'b0, f3, addr, 32'h0, 2, exp_mis);
    chk({tag, ".rd"}, rd, exp_rd);
  endtask

  initial begin
    int acc_n;
    int rsp_n;
    logic tr;
`ifdef DM_MISALIGN_TRAP_EN
    tr = 1'b1;
`else
    tr = 1'b0;
`endif
    reset = 1'b1;
    req_valid = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Funct3 = 3'b000;
    a = '0;
    wd = '0;
    #3;
    chk("rst.ready", {31'h0, req_ready}, 32'h1);
    chk("rst.rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rst.rd", rd, 32'h0);
    chk("rst.mis", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    st_op("t1.sw", 3'b010, 9'h010, 32'hDEADBEEF, 1'b0);
    ld_op("t1.lw", 3'b010, 9'h010, 32'hDEADBEEF, 1'b0);

    st_op("t2.sw", 3'b010, 9'h010, 32'h11223344, 1'b0);
    st_op("t2.sb", 3'b000, 9'h013, 32'h000000A5, 1'b0);
    ld_op("t2.lw", 3'b010, 9'h010, 32'hA5223344, 1'b0);
    ld_op("t2.lb", 3'b000, 9'h013, 32'hFFFFFFA5, 1'b0);
    ld_op("t2.lbu", 3'b100, 9'h013, 32'h000000A5, 1'b0);
    ld_op("t2.lb2", 3'b000, 9'h012, 32'h00000022, 1'b0);

    st_op("t3.sw", 3'b010, 9'h020, 32'h12345678, 1'b0);
    st_op("t3.sh", 3'b001, 9'h022, 32'h00008001, 1'b0);
    ld_op("t3.lh", 3'b001, 9'h022, 32'hFFFF8001, 1'b0);
    ld_op("t3.lhu", 3'b101, 9'h022, 32'h00008001, 1'b0);
    ld_op("t3.lo", 3'b101, 9'h020, 32'h00005678, 1'b0);
    ld_op("t3.lw", 3'b010, 9'h020, 32'h80015678, 1'b0);

    st_op("t4.sw", 3'b010, 9'h004, 32'hCAFEF00D, 1'b0);
    ld_op("t4.pre", 3'b010, 9'h010, 32'hA5223344, 1'b0);
    if (tr) begin
      ld_op("t4.lw5", 3'b010, 9'h005, 32'hA5223344, 1'b1);
      st_op("t4.sw6", 3'b010, 9'h006, 32'h55555555, 1'b1);
      ld_op("t4.lw4", 3'b010, 9'h004, 32'hCAFEF00D, 1'b0);
      ld_op("t4.lh3", 3'b001, 9'h023, 32'hCAFEF00D, 1'b1);
    end else begin
      ld_op("t4.lw5", 3'b010, 9'h005, 32'hCAFEF00D, 1'b0);
      st_op("t4.sw6", 3'b010, 9'h006, 32'h55555555, 1'b0);
      ld_op("t4.lw4", 3'b010, 9'h004, 32'h55555555, 1'b0);
      ld_op("t4.lh3", 3'b001, 9'h023, 32'hFFFF8001, 1'b0);
    end

    // Load accepted, then reset pulsed while in RD_WAIT.
    @(negedge clk);
    req_valid = 1'b1;
    MemRead = 1'b1;
    Funct3 = 3'b010;
    a = 9'h010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    MemRead = 1'b0;
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    rsp_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) rsp_n++;
    end
    chk("t5.norsp", rsp_n, 0);
    chk("t5.ready", {31'h0, req_ready}, 32'h1);
    chk("t5.rd", rd, 32'h0);
    ld_op("t5.keep", 3'b010, 9'h010, 32'hA5223344, 1'b0);

    do_req("t6.both", 1'b1, 1'b1, 3'b010, 9'h020, 32'hFFFFFFFF, 2, 1'b0);
    chk("t6.both.rd", rd, 32'h80015678);
    ld_op("t6.chk", 3'b010, 9'h020, 32'h80015678, 1'b0);

    // Request held valid across busy cycles: one accept per IDLE.
    @(negedge clk);
    req_valid = 1'b1;
    MemRead = 1'b1;
    Funct3 = 3'b010;
    a = 9'h010;
    acc_n = 0;
    rsp_n = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0 && req_ready) acc_n++;
      if (i == 0 && req_ready) acc_n++;
      @(posedge clk);
      #1;
      if (rsp_valid) rsp_n++;
    end
    req_valid = 1'b0;
    MemRead = 1'b0;
    chk("t6.acc", acc_n, 3);
    chk("t6.rsp", rsp_n, 3);
    chk("t6.rd", rd, 32'hA5223344);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
